magic_square_sequencer: RTL

- Serial front end and check sequencer for the 3x3 magic-square checker datapath.
- Accepts nine 4-bit digits one per handshake, in row-major order (cell 0..8 = num1..num9).
- Checks range and uniqueness on the fly during loading.
- Then steps one shared 6-bit accumulator through the 8 lines (3 rows, 3 cols, 2 diagonals), holding the verdict until the consumer takes it.

---
 rtl/magic_square_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/magic_square_sequencer.sv
// Serial loader and line-sum sequencer for the 3x3 magic-square checker.
// Optional MAGIC_EARLY_EXIT_EN: skip or cut short the sum pass once the verdict is known.
module magic_square_sequencer #(
  parameter int MAGIC_SUM = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       is_magic,
  output logic       range_err,
  output logic       dup_err,
  output logic       sum_err,
  output logic [2:0] bad_line,
  output logic       busy
);

`ifdef MAGIC_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [5:0] MAGIC6 = 6'(MAGIC_SUM);

  typedef enum logic [1:0] {LOAD, SUM, REPORT} state_t;

  state_t     state, state_next;
  logic [3:0] cells [9];
  logic [3:0] idx;
  logic [2:0] line;
  logic [1:0] elem;
  logic [5:0] acc;
  logic [8:0] seen;
  logic       range_q, dup_q, sum_q;
  logic [2:0] bad_q;

  logic       accept, last_accept, done;
  logic       digit_ok, dup_hit, err_next, line_bad;
  logic [8:0] digit_bit;
  logic [3:0] cell_val;
  logic [5:0] sum_now;

  // Each line is an arithmetic progression of cell indices: base + elem*step.
  function automatic logic [3:0] line_cell(input logic [2:0] ln, input logic [1:0] el);
    logic [3:0] base;
    logic [3:0] step;
    base = 4'd0;
    step = 4'd1;
    case (ln)
      3'd0: begin base = 4'd0; step = 4'd1; end
      3'd1: begin base = 4'd3; step = 4'd1; end
      3'd2: begin base = 4'd6; step = 4'd1; end
      3'd3: begin base = 4'd0; step = 4'd3; end
      3'd4: begin base = 4'd1; step = 4'd3; end
      3'd5: begin base = 4'd2; step = 4'd3; end
      3'd6: begin base = 4'd0; step = 4'd4; end
      default: begin base = 4'd2; step = 4'd2; end
    endcase
    return base + step * {2'b00, el};
  endfunction

  assign accept      = in_valid && (state == LOAD);
  assign last_accept = accept && (idx == 4'd8);
  assign done        = (state == REPORT) && result_ready;

  assign digit_ok  = (in_digit != 4'd0) && (in_digit <= 4'd9);
  assign digit_bit = digit_ok ? (9'b1 << (in_digit - 4'd1)) : 9'b0;
  assign dup_hit   = |(seen & digit_bit);
  assign err_next  = range_q || dup_q || !digit_ok || dup_hit;

  assign cell_val = cells[line_cell(line, elem)];
  assign sum_now  = acc + {2'b00, cell_val};
  assign line_bad = (state == SUM) && (elem == 2'd2) && (sum_now != MAGIC6);

  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    is_magic     = 1'b0;
    range_err    = 1'b0;
    dup_err      = 1'b0;
    sum_err      = 1'b0;
    bad_line     = 3'd0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (last_accept) state_next = (EARLY_EXIT && err_next) ? REPORT : SUM;
      end
      SUM: begin
        busy = 1'b1;
        if (elem == 2'd2 && (line == 3'd7 || (EARLY_EXIT && line_bad))) state_next = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        is_magic     = !range_q && !dup_q && !sum_q;
        range_err    = range_q;
        dup_err      = dup_q;
        sum_err      = sum_q;
        bad_line     = bad_q;
        if (result_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Cell storage carries data only; every cell is rewritten before it is read.
  always_ff @(posedge clock) begin
    if (accept) cells[idx] <= in_digit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx     <= 4'd0;
      line    <= 3'd0;
      elem    <= 2'd0;
      acc     <= 6'd0;
      seen    <= 9'd0;
      range_q <= 1'b0;
      dup_q   <= 1'b0;
      sum_q   <= 1'b0;
      bad_q   <= 3'd0;
    end else begin
      if (accept) begin
        idx  <= last_accept ? 4'd0 : idx + 4'd1;
        seen <= seen | digit_bit;
        if (!digit_ok) range_q <= 1'b1;
        if (dup_hit)   dup_q   <= 1'b1;
        if (last_accept) begin
          line <= 3'd0;
          elem <= 2'd0;
        end
      end
      if (state == SUM) begin
        acc <= (elem == 2'd0) ? {2'b00, cell_val} : sum_now;
        if (elem == 2'd2) begin
          elem <= 2'd0;
          line <= line + 3'd1;
        end else begin
          elem <= elem + 2'd1;
        end
        // Only the first failing line is reported; later ones just keep sum_err set.
        if (line_bad) begin
          sum_q <= 1'b1;
          if (!sum_q) bad_q <= line;
        end
      end
      if (done) begin
        idx     <= 4'd0;
        acc     <= 6'd0;
        seen    <= 9'd0;
        range_q <= 1'b0;
        dup_q   <= 1'b0;
        sum_q   <= 1'b0;
        bad_q   <= 3'd0;
      end
    end
  end

endmodule
